// File: rtl/stream_delay_multi.sv
// rtl/stream_delay_multi.sv - multi-channel valid/ready stall injector with per-channel statistics
//
// Purpose: inserts a run-time selectable number of stall cycles on each of
// NumChan independent valid/ready streams. The payload path is a pure wire.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   mode_i       0 pass-through, 1 fixed, 2 programmed, 3 LFSR random (masked)
//   cfg_delay_i  per-channel delay (mode 2) or AND-mask (mode 3)
//   stat_clr_i   clears every stall counter
//   valid_i / ready_o / payload_i   upstream side, one bit/slice per channel
//   valid_o / ready_i / payload_o   downstream side, one bit/slice per channel
//   stall_cnt_o  saturating count of stall cycles inserted, per channel
module stream_delay_multi #(
  parameter int unsigned NumChan    = 2,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned DelayWidth = 4,
  parameter int unsigned FixedDelay = 1,
  parameter logic [15:0] Seed       = 16'hACE1,
  parameter int unsigned StatWidth  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [1:0]                      mode_i,
  input  logic [NumChan*DelayWidth-1:0]   cfg_delay_i,
  input  logic                            stat_clr_i,
  input  logic [NumChan-1:0]              valid_i,
  output logic [NumChan-1:0]              ready_o,
  input  logic [NumChan*DataWidth-1:0]    payload_i,
  output logic [NumChan-1:0]              valid_o,
  input  logic [NumChan-1:0]              ready_i,
  output logic [NumChan*DataWidth-1:0]    payload_o,
  output logic [NumChan*StatWidth-1:0]    stall_cnt_o
);

  if (FixedDelay >= (1 << DelayWidth)) begin : g_bad_fixed_delay
    $error("FixedDelay does not fit in DelayWidth bits");
  end
  if (NumChan < 1 || NumChan > 16) begin : g_bad_num_chan
    $error("NumChan must be in 1..16");
  end
  if (DelayWidth < 1 || DelayWidth > 8) begin : g_bad_delay_width
    $error("DelayWidth must be in 1..8");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_e;

  assign payload_o = payload_i;

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    localparam logic [15:0] SeedMix  = Seed ^ 16'(c + 1);
    localparam logic [15:0] ChanSeed = (SeedMix == 16'h0000) ? 16'h0001 : SeedMix;

    state_e                state_q, state_d;
    logic [DelayWidth-1:0] cnt_q, cnt_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [StatWidth-1:0]  stat_q, stat_d;
    logic [DelayWidth-1:0] cfg, d_sel;
    logic                  lfsr_fb;
    logic                  vo, ro;

    assign cfg     = cfg_delay_i[c*DelayWidth +: DelayWidth];
    // Fibonacci taps 16,14,13,11
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_comb begin
      d_sel = '0;
      case (mode_i)
        2'd0:    d_sel = '0;
        2'd1:    d_sel = DelayWidth'(FixedDelay);
        2'd2:    d_sel = cfg;
        default: d_sel = lfsr_q[DelayWidth-1:0] & cfg;
      endcase
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lfsr_d  = lfsr_q;
      vo      = 1'b0;
      ro      = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_i[c]) begin
            if (mode_i == 2'd3) begin
              lfsr_d = {lfsr_q[14:0], lfsr_fb};
            end
            if (d_sel == '0) begin
              // zero delay: the channel is transparent in the load cycle
              vo = 1'b1;
              ro = ready_i[c];
              if (!ready_i[c]) begin
                state_d = S_READY;
              end
            end else if (d_sel == DelayWidth'(1)) begin
              state_d = S_READY;
            end else begin
              // WAIT spans d-1 cycles; counter reaches zero in its last one
              state_d = S_WAIT;
              cnt_d   = d_sel - DelayWidth'(2);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_d = S_READY;
          end else begin
            cnt_d = cnt_q - DelayWidth'(1);
          end
        end
        S_READY: begin
          vo = 1'b1;
          ro = ready_i[c];
          if (ready_i[c]) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (rst_i) begin
        vo = 1'b0;
        ro = 1'b0;
      end
    end

    always_comb begin
      stat_d = stat_q;
      if (stat_clr_i) begin
        stat_d = '0;
      end else if (valid_i[c] && !vo && (stat_q != {StatWidth{1'b1}})) begin
        stat_d = stat_q + StatWidth'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        lfsr_q  <= ChanSeed;
        stat_q  <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lfsr_q  <= lfsr_d;
        stat_q  <= stat_d;
      end
    end

    assign valid_o[c]                             = vo;
    assign ready_o[c]                             = ro;
    assign stall_cnt_o[c*StatWidth +: StatWidth]  = stat_q;
  end

endmodule

// File: tb/tb_stream_delay_multi.sv
// tb/tb_stream_delay_multi.sv - directed self-checking bench for stream_delay_multi
module tb_stream_delay_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [7:0]  cfg;
  logic        stat_clr;
  logic [1:0]  vin, rdy_o, vout, rdy_i;
  logic [63:0] pay_i, pay_o;
  logic [31:0] stall;

  logic        s_rst;
  logic [1:0]  s_mode;
  logic [3:0]  s_cfg;
  logic        s_clr;
  logic [0:0]  s_vin, s_rdy_o, s_vout, s_rdy_i;
  logic [7:0]  s_pay_i, s_pay_o;
  logic [3:0]  s_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_delay_multi #(
    .NumChan(2), .DataWidth(32), .DelayWidth(4), .FixedDelay(3),
    .Seed(16'hACE1), .StatWidth(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .cfg_delay_i(cfg),
    .stat_clr_i(stat_clr), .valid_i(vin), .ready_o(rdy_o),
    .payload_i(pay_i), .valid_o(vout), .ready_i(rdy_i),
    .payload_o(pay_o), .stall_cnt_o(stall)
  );

  stream_delay_multi #(
    .NumChan(1), .DataWidth(8), .DelayWidth(4), .FixedDelay(5),
    .Seed(16'hACE1), .StatWidth(4)
  ) dut_s (
    .clk_i(clk), .rst_i(s_rst), .mode_i(s_mode), .cfg_delay_i(s_cfg),
    .stat_clr_i(s_clr), .valid_i(s_vin), .ready_o(s_rdy_o),
    .payload_i(s_pay_i), .valid_o(s_vout), .ready_i(s_rdy_i),
    .payload_o(s_pay_o), .stall_cnt_o(s_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  initial begin
    logic [15:0] ref_lfsr;
    int          hs0, hs1, meas, exp_d;

    rst = 1'b1; mode = 2'd0; cfg = 8'h00; stat_clr = 1'b0;
    vin = 2'b00; rdy_i = 2'b00; pay_i = 64'h0;
    s_rst = 1'b1; s_mode = 2'd1; s_cfg = 4'h0; s_clr = 1'b0;
    s_vin = 1'b0; s_rdy_i = 1'b0; s_pay_i = 8'h00;
    cyc();
    vin = 2'b11; rdy_i = 2'b11;
    #1;
    chk("rst_valid_o", 64'(vout), 64'h0);
    chk("rst_ready_o", 64'(rdy_o), 64'h0);
    cyc();
    rst = 1'b0; s_rst = 1'b0; vin = 2'b00;
    #1;
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_stall_s", 64'(s_stall), 64'h0);

    // mode 0: transparent, one handshake per cycle on both channels
    mode = 2'd0; rdy_i = 2'b11; vin = 2'b11; hs0 = 0; hs1 = 0;
    for (int i = 0; i < 10; i++) begin
      pay_i = {32'(i * 3 + 1), 32'(i + 100)};
      #1;
      chk("m0_valid", 64'(vout), 64'h3);
      chk("m0_payload", pay_o, pay_i);
      hs0 += int'(vout[0] & rdy_o[0]);
      hs1 += int'(vout[1] & rdy_o[1]);
      cyc();
    end
    vin = 2'b00;
    #1;
    chk("m0_hs_ch0", 64'(hs0), 64'd10);
    chk("m0_hs_ch1", 64'(hs1), 64'd10);
    chk("m0_stall", 64'(stall), 64'h0);

    // mode 1: FixedDelay=3 on ch0
    mode = 2'd1; vin = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("m1_stall_phase", 64'(vout), 64'h0);
      cyc();
    end
    #1;
    chk("m1_valid_t3", 64'(vout), 64'h1);
    chk("m1_ready_t3", 64'(rdy_o), 64'h1);
    cyc();
    vin = 2'b00;
    #1;
    chk("m1_stall_cnt", 64'(stall[15:0]), 64'd3);

    // mode 2: ch0 d=0, ch1 d=5 with two extra cycles of backpressure
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0; mode = 2'd2; cfg = {4'd5, 4'd0}; vin = 2'b11; rdy_i = 2'b01;
    #1;
    chk("m2_t_valid", 64'(vout), 64'h1);
    chk("m2_t_ready", 64'(rdy_o), 64'h1);
    cyc();
    vin = 2'b10;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("m2_ch1_stall", 64'(vout), 64'h0);
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("m2_ch1_valid_bp", 64'(vout), 64'h2);
      chk("m2_ch1_ready_bp", 64'(rdy_o), 64'h0);
      cyc();
    end
    rdy_i = 2'b11;
    #1;
    chk("m2_ch1_hs_valid", 64'(vout), 64'h2);
    chk("m2_ch1_hs_ready", 64'(rdy_o), 64'h2);
    cyc();
    vin = 2'b00;
    #1;
    chk("m2_stall_cnt", 64'(stall), {32'h0, 16'd5, 16'd0});

    // mode 3: random delays on ch0 against a reference LFSR
    mode = 2'd3; cfg = {4'h0, 4'hF}; rdy_i = 2'b11; vin = 2'b01;
    ref_lfsr = 16'hACE1 ^ 16'h0001;
    for (int n = 0; n < 100; n++) begin
      exp_d = int'(ref_lfsr[3:0]);
      ref_lfsr = lfsr_next(ref_lfsr);
      meas = 0;
      #1;
      while (!vout[0] && meas < 20) begin
        cyc();
        #1;
        meas++;
      end
      chk("m3_delay", 64'(meas), 64'(exp_d));
      cyc();
    end
    cfg = 8'h00;
    for (int n = 0; n < 10; n++) begin
      #1;
      chk("m3_mask0_valid", 64'(vout[0]), 64'h1);
      cyc();
    end
    vin = 2'b00;

    // reset during WAIT drops progress and restarts a full delay
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0; mode = 2'd2; cfg = {4'h0, 4'h7}; vin = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rw_pre_stall", 64'(vout), 64'h0);
      cyc();
    end
    #1;
    chk("rw_pre_cnt", 64'(stall[15:0]), 64'd3);
    rst = 1'b1;
    #1;
    chk("rw_rst_valid", 64'(vout), 64'h0);
    chk("rw_rst_ready", 64'(rdy_o), 64'h0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rw_cnt_cleared", 64'(stall[15:0]), 64'd0);
    chk("rw_reload", 64'(vout), 64'h0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      #1;
      chk("rw_restall", 64'(vout), 64'h0);
    end
    cyc();
    #1;
    chk("rw_valid_t7", 64'(vout), 64'h1);
    cyc();
    vin = 2'b00;
    #1;
    chk("rw_post_cnt", 64'(stall[15:0]), 64'd7);

    // saturation on the 4-bit counter, FixedDelay=5
    s_mode = 2'd1; s_rdy_i = 1'b1; s_vin = 1'b1; hs0 = 0;
    for (int i = 0; i < 24; i++) begin
      #1;
      hs0 += int'(s_vout[0] & s_rdy_o[0]);
      cyc();
    end
    s_vin = 1'b0;
    #1;
    chk("sat_handshakes", 64'(hs0), 64'd4);
    chk("sat_hold", 64'(s_stall), 64'd15);
    s_vin = 1'b1; s_clr = 1'b1;
    cyc();
    s_clr = 1'b0;
    #1;
    chk("sat_clr_priority", 64'(s_stall), 64'd0);
    cyc();
    #1;
    chk("sat_after_clr", 64'(s_stall), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_delay_multi.md
Name: stream_delay_multi

Overview:
- Parametrised successor to the single-channel handshake delay element.
- Inserts controllable stall cycles on NumChan independent valid/ready streams, for testbenches and stress configurations of the FPU/cache interfaces.
- Each channel's delay is selected at run time: pass-through, fixed parameter, per-channel programmed value, or LFSR-random masked by the programmed value.
- Each channel counts the stall cycles it has inserted.

Parameters:
- NumChan, 2, number of independent stream channels (1..16).
- DataWidth, 32, payload bits per channel.
- DelayWidth, 4, counter width; maximum delay is 2^DelayWidth-1 cycles (1..8).
- FixedDelay, 1, delay used in mode 1; must fit in DelayWidth bits.
- Seed, 16'hACE1, LFSR base seed; channel c is seeded with Seed ^ (c+1), forced to 16'h0001 if that is zero.
- StatWidth, 16, width of each stall statistics counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- mode_i  in  2  0 pass-through, 1 fixed, 2 programmed, 3 random; global to all channels.
- cfg_delay_i  in  NumChan*DelayWidth  channel c slice [c*DelayWidth +: DelayWidth]; the delay in mode 2, the AND-mask in mode 3.
- stat_clr_i  in  1  clears all statistics counters.
- valid_i  in  NumChan  upstream valid per channel.
- ready_o  out  NumChan  upstream ready per channel.
- payload_i  in  NumChan*DataWidth  upstream payload.
- valid_o  out  NumChan  downstream valid.
- ready_i  in  NumChan  downstream ready.
- payload_o  out  NumChan*DataWidth  downstream payload; combinational copy of payload_i, no storage.
- stall_cnt_o  out  NumChan*StatWidth  inserted stall cycles per channel.

Behaviour:
- Channels are fully independent; each has its own FSM with states IDLE, WAIT and READY, a DelayWidth-bit down-counter and a 16-bit Fibonacci LFSR (taps 16,14,13,11).
- Upstream must hold valid_i and payload_i stable until ready_o=1; this is a protocol requirement, and the block does not check it.
- Delay sampling:
  - d is evaluated only in IDLE when valid_i=1 (the "load" cycle t).
  - mode 0: d=0; mode 1: d=FixedDelay; mode 2: d=cfg slice; mode 3: d = LFSR[DelayWidth-1:0] & cfg slice.
  - The LFSR advances once per load, and only in mode 3.
  - Changes to mode_i or cfg_delay_i while a channel is in WAIT or READY do not affect that transfer.
- Timing:
  - d=0: valid_o=valid_i and ready_o=ready_i combinationally in cycle t. If ready_i=1 the channel stays IDLE; otherwise it goes to READY.
  - d>=1: valid_o and ready_o are 0 in cycles t..t+d-1, so they first assert in cycle t+d. For d=1 the FSM goes directly to READY; otherwise it goes to WAIT and counts down.
  - READY: valid_o=1 and ready_o=ready_i. On ready_i=1 the handshake completes and the FSM returns to IDLE.
  - The next load on that channel is no earlier than the following cycle, giving a maximum of one transfer per d+1 cycles when d>=1, and one per cycle when d=0.
- Outside the cases above, valid_o=0 and ready_o=0.
- Statistics:
  - stall_cnt increments in every cycle where valid_i=1 and valid_o=0.
  - It saturates at 2^StatWidth-1.
  - stat_clr_i clears all counters to 0 and takes priority over an increment in the same cycle.
- Reset (rst_i=1 at a rising edge):
  - All FSMs return to IDLE and all counters to 0.
  - LFSRs reload their seeds; stall_cnt clears.
  - While rst_i=1, valid_o=0 and ready_o=0 regardless of state.
  - A reset mid-transfer drops that transfer's delay progress; once rst_i is released, the still-asserted valid_i is re-loaded as a new transfer.
- Illegal values: FixedDelay must be below 2^DelayWidth; an out-of-range value is an elaboration error (assertion).

Test Plan:
- Mode 0, NumChan=2, both ready_i=1, valid_i held high 10 cycles -> 10 handshakes per channel, valid_o==valid_i every cycle, stall_cnt=0.
- Mode 1, FixedDelay=3, single valid_i pulse held until ready_o -> valid_o rises exactly 3 cycles after valid_i; handshake in cycle t+3; stall_cnt=3.
- Mode 2, cfg ch0=0, ch1=5, ready_i ch1 low for 2 extra cycles -> ch0 passes in cycle t; ch1 valid_o at t+5, handshake at t+7; stall_cnt ch1=5, ch0=0.
- Mode 3, mask 4'hF, 100 transfers on ch0 -> observed delays match a reference LFSR seeded with Seed^1; mask 4'h0 gives d=0 on every transfer.
- Reset asserted while ch0 is in WAIT (d=7, 3 cycles elapsed), valid_i kept high -> valid_o=0 during reset; after release, a full 7-cycle delay restarts; stall_cnt restarts from 0.
- Saturation with StatWidth=4, mode 1, FixedDelay=5, 4 transfers -> stall_cnt holds at 15; stat_clr_i coincident with a stall cycle yields 0.
